// File: rtl/keypad_matrix_scanner_if.sv
// Keypad bundle: matrix row/column lines plus the decoded key outputs.
// master = scanner side, slave = board / user-logic side.
interface keypad_matrix_scanner_if;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  key_col,
        output key_row,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output key_col,
        input  key_row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad row scanner with frame-level debounce and a one-cycle press strobe.
// Optional auto-repeat of the held key is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_matrix_scanner #(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_FRAMES  = 32
) (
    input logic                     clock_div,
    input logic                     reset,
    keypad_matrix_scanner_if.master kp
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } hold_state_t;

    localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

    if ((DEBOUNCE_SCANS < 2) || (DEBOUNCE_SCANS > 15) ||
        (REPEAT_FRAMES < 2) || (REPEAT_FRAMES > 255)) begin : g_param_check
        $error("keypad_matrix_scanner: parameter out of legal range");
    end

    hold_state_t state_r, state_next_s;
    logic [1:0]  row_idx_r, drive_row_r;
    logic        drive_valid_r;
    logic [15:0] snapshot_r, frame_s;
    logic [3:0]  sample_s, enc_s, cand_code_s, prev_code_r;
    logic [4:0]  bit_cnt_s;
    logic        cand_pressed_s, prev_pressed_r;
    logic [3:0]  stab_cnt_r, stab_next_s;
    logic        frame_done_s, same_s, accept_s;
    logic        strobe_s, load_code_s, rep_fire_s;
    logic [3:0]  key_row_r, key_code_r;
    logic        key_valid_r;

    // The sample taken at this edge belongs to the row driven during the previous cycle.
    assign sample_s     = ~kp.key_col;
    assign frame_done_s = drive_valid_r && (drive_row_r == 2'd3);

    // Current snapshot with this edge's row sample merged in.
    always_comb begin
        frame_s = snapshot_r;
        case (drive_row_r)
            2'd0:    frame_s[3:0]   = sample_s;
            2'd1:    frame_s[7:4]   = sample_s;
            2'd2:    frame_s[11:8]  = sample_s;
            2'd3:    frame_s[15:12] = sample_s;
            default: frame_s        = snapshot_r;
        endcase
    end

    // Count pressed switches and remember the index of one; only a lone key is a candidate.
    always_comb begin
        bit_cnt_s = 5'd0;
        enc_s     = 4'd0;
        for (int i = 0; i < 16; i++) begin
            bit_cnt_s = bit_cnt_s + {4'd0, frame_s[i]};
            enc_s     = frame_s[i] ? 4'(i) : enc_s;
        end
    end

    assign cand_pressed_s = (bit_cnt_s == 5'd1);
    assign cand_code_s    = cand_pressed_s ? enc_s : 4'd0;
    assign same_s         = (cand_pressed_s == prev_pressed_r) && (cand_code_s == prev_code_r);
    assign accept_s       = frame_done_s && (stab_next_s == DEB_MAX) && (stab_cnt_r != DEB_MAX);

    // Saturating count of consecutive identical frame candidates.
    always_comb begin
        stab_next_s = 4'd1;
        if (same_s) begin
            stab_next_s = (stab_cnt_r == DEB_MAX) ? DEB_MAX : (stab_cnt_r + 4'd1);
        end else begin
            stab_next_s = 4'd1;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 1);
    logic [7:0] rep_cnt_r;
    logic       rep_match_s;

    assign rep_match_s = frame_done_s && (state_r == HELD) && cand_pressed_s &&
                         (cand_code_s == key_code_r) && !accept_s;
    assign rep_fire_s  = rep_match_s && (rep_cnt_r == REP_LAST);

    // Frames spent on the held key since its acceptance or its last repeat strobe.
    always_ff @(posedge clock_div) begin
        if (reset) begin
            rep_cnt_r <= 8'd0;
        end else if (frame_done_s) begin
            rep_cnt_r <= (rep_match_s && !rep_fire_s) ? (rep_cnt_r + 8'd1) : 8'd0;
        end else begin
            rep_cnt_r <= rep_cnt_r;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Hold-status transitions; re-accepting the already-held key must not strobe.
    always_comb begin
        state_next_s = state_r;
        strobe_s     = 1'b0;
        load_code_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && cand_pressed_s) begin
                    state_next_s = HELD;
                    strobe_s     = 1'b1;
                    load_code_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HELD: begin
                if (accept_s && !cand_pressed_s) begin
                    state_next_s = IDLE;
                end else if (accept_s && (cand_code_s != key_code_r)) begin
                    strobe_s    = 1'b1;
                    load_code_s = 1'b1;
                end else if (rep_fire_s) begin
                    strobe_s = 1'b1;
                end else begin
                    state_next_s = HELD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Hold-status register.
    always_ff @(posedge clock_div) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Row sweep, snapshot capture, debounce history and registered outputs.
    always_ff @(posedge clock_div) begin
        if (reset) begin
            row_idx_r      <= 2'd0;
            drive_row_r    <= 2'd0;
            drive_valid_r  <= 1'b0;
            snapshot_r     <= 16'd0;
            stab_cnt_r     <= 4'd0;
            prev_pressed_r <= 1'b0;
            prev_code_r    <= 4'd0;
            key_row_r      <= 4'b1111;
            key_code_r     <= 4'd0;
            key_valid_r    <= 1'b0;
        end else begin
            row_idx_r     <= row_idx_r + 2'd1;
            drive_row_r   <= row_idx_r;
            drive_valid_r <= 1'b1;
            key_row_r     <= ~(4'b0001 << row_idx_r);
            snapshot_r    <= drive_valid_r ? frame_s : snapshot_r;
            if (frame_done_s) begin
                stab_cnt_r     <= stab_next_s;
                prev_pressed_r <= cand_pressed_s;
                prev_code_r    <= cand_code_s;
            end else begin
                stab_cnt_r     <= stab_cnt_r;
                prev_pressed_r <= prev_pressed_r;
                prev_code_r    <= prev_code_r;
            end
            key_code_r  <= load_code_s ? cand_code_s : key_code_r;
            key_valid_r <= strobe_s;
        end
    end

    assign kp.key_row   = key_row_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_held  = (state_r == HELD);
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: a combinational switch-matrix model
// answers the row drive, and edges are counted from the first edge with reset low.
module tb_keypad_matrix_scanner;
    logic        clock_div = 1'b0;
    logic        reset     = 1'b1;
    logic [15:0] keys      = 16'h0000;
    int          total     = 0;
    int          bad       = 0;
    int          vcnt      = 0;
    int          dbl       = 0;
    logic        prev_v    = 1'b0;
    int          edge_no   = 0;
    int          base      = 0;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_A = 7;
    localparam int REP_B = 10;
`else
    localparam int REP_A = 0;
    localparam int REP_B = 0;
`endif

    keypad_matrix_scanner_if kif ();

    keypad_matrix_scanner #(
        .DEBOUNCE_SCANS(4),
        .REPEAT_FRAMES (4)
    ) dut (
        .clock_div(clock_div),
        .reset    (reset),
        .kp       (kif.master)
    );

    always #5 clock_div = ~clock_div;

    // Switch matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        kif.key_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.key_row[r] && keys[4*r+c]) kif.key_col[c] = 1'b0;
            end
        end
    end

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clock_div) begin
        if (kif.key_valid) begin
            vcnt++;
            if (prev_v) dbl++;
        end
        prev_v = kif.key_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_to(input int k);
        while (edge_no < k) begin
            @(posedge clock_div);
            #2;
            edge_no++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clock_div);
            #2;
        end
    endtask

    initial begin
        // Reset values, then idle sweep.
        do_reset();
        check("rst_row",   kif.key_row,   4'b1111);
        check("rst_code",  kif.key_code,  4'd0);
        check("rst_valid", kif.key_valid, 1'b0);
        check("rst_held",  kif.key_held,  1'b0);
        reset = 1'b0; edge_no = 0;
        step_to(1); check("sweep_e1", kif.key_row, 4'b1110);
        step_to(2); check("sweep_e2", kif.key_row, 4'b1101);
        step_to(3); check("sweep_e3", kif.key_row, 4'b1011);
        step_to(4); check("sweep_e4", kif.key_row, 4'b0111);
        step_to(5); check("sweep_e5", kif.key_row, 4'b1110);
        base = vcnt;
        step_to(200);
        check("idle_strobes", vcnt - base,  0);
        check("idle_held",    kif.key_held, 1'b0);

        // Key 6 held from reset release: strobe right after edge 17.
        keys = 16'h0040;
        do_reset();
        reset = 1'b0; edge_no = 0;
        step_to(16);
        check("k6_e16_valid", kif.key_valid, 1'b0);
        check("k6_e16_held",  kif.key_held,  1'b0);
        step_to(17);
        check("k6_e17_valid", kif.key_valid, 1'b1);
        check("k6_e17_code",  kif.key_code,  4'd6);
        check("k6_e17_held",  kif.key_held,  1'b1);
        step_to(18);
        check("k6_e18_valid", kif.key_valid, 1'b0);
        base = vcnt;
        step_to(138);
        check("k6_hold_strobes", vcnt - base,  REP_A);
        check("k6_hold_held",    kif.key_held, 1'b1);

        // Release: first clean frame completes at edge 141, release accepted at edge 153.
        keys = 16'h0000; base = vcnt;
        step_to(152); check("rel_e152_held", kif.key_held, 1'b1);
        step_to(153);
        check("rel_e153_held", kif.key_held, 1'b0);
        check("rel_code",      kif.key_code, 4'd6);
        check("rel_strobes",   vcnt - base,  0);

        // Chatter: key 6 toggles every 3 frames, never stable for 4.
        step_to(157); base = vcnt;
        keys = 16'h0040; step_to(169);
        keys = 16'h0000; step_to(181);
        keys = 16'h0040; step_to(193);
        keys = 16'h0000; step_to(205);
        check("chat_strobes", vcnt - base,  0);
        check("chat_held",    kif.key_held, 1'b0);

        // Key 6 pressed again, then keys 1+2 together act as a release.
        keys = 16'h0040;
        step_to(220); check("k6b_e220_held", kif.key_held, 1'b0);
        step_to(221);
        check("k6b_e221_valid", kif.key_valid, 1'b1);
        check("k6b_e221_code",  kif.key_code,  4'd6);
        step_to(225);
        keys = 16'h0006; base = vcnt;
        step_to(240); check("ghost_e240_held", kif.key_held, 1'b1);
        step_to(241);
        check("ghost_e241_held", kif.key_held, 1'b0);
        check("ghost_code",      kif.key_code, 4'd6);
        check("ghost_strobes",   vcnt - base,  0);

        // Key 3, then a direct change to key 12 with no release frame.
        keys = 16'h0008;
        step_to(257);
        check("k3_valid", kif.key_valid, 1'b1);
        check("k3_code",  kif.key_code,  4'd3);
        keys = 16'h1000;
        step_to(265);
        check("ab_e265_held", kif.key_held, 1'b1);
        check("ab_e265_code", kif.key_code, 4'd3);
        step_to(272); check("ab_e272_valid", kif.key_valid, 1'b0);
        step_to(273);
        check("ab_e273_valid", kif.key_valid, 1'b1);
        check("ab_e273_code",  kif.key_code,  4'd12);
        check("ab_e273_held",  kif.key_held,  1'b1);
        step_to(274);
        check("ab_e274_valid", kif.key_valid, 1'b0);
        base = vcnt;
        step_to(434);
        check("k12_long_strobes", vcnt - base,  REP_B);
        check("k12_long_code",    kif.key_code, 4'd12);

        // Reset mid-frame with key 12 still down, then a fresh debounce from row 0.
        reset = 1'b1;
        @(posedge clock_div); #2;
        check("mid_rst_row",   kif.key_row,   4'b1111);
        check("mid_rst_code",  kif.key_code,  4'd0);
        check("mid_rst_held",  kif.key_held,  1'b0);
        check("mid_rst_valid", kif.key_valid, 1'b0);
        reset = 1'b0; edge_no = 0;
        step_to(1);  check("mid_e1_row",    kif.key_row,   4'b1110);
        step_to(16); check("mid_e16_held",  kif.key_held,  1'b0);
        step_to(17);
        check("mid_e17_valid", kif.key_valid, 1'b1);
        check("mid_e17_code",  kif.key_code,  4'd12);
        step_to(20);

        check("no_back_to_back", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Scans a 4x4 key matrix on the lab board: it drives one row low at a time and reads the column lines back. Per-frame snapshots are debounced, and each accepted key press is reported as a 4-bit key code with a one-cycle valid strobe. This block is the input-side counterpart of the row-scanned dot-matrix driver and runs on the same divided scan clock. Its outputs feed the user-logic FSMs, e.g. manual override of the traffic light.

## Interface
- DEBOUNCE_SCANS, 4: consecutive identical frame results needed to accept a press or a release; legal range 2..15.
- REPEAT_FRAMES, 32: auto-repeat period in frames; used only when KEYPAD_REPEAT_EN is defined; legal range 2..255.
- clock_div  input  1  divided scan clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key_col  input  4  column sense lines, pulled up, active-low; bit c = column c.
- key_row  output  4  row drive, active-low one-cold; bit r = row r.
- key_code  output  4  code of the last accepted key, 4*r + c.
- key_valid  output  1  one-cycle strobe on each accepted press.
- key_held  output  1  high while an accepted key remains debounced-pressed.

## Operation
- Row counter `row_idx` (2 bits) advances 0,1,2,3,0,… every clock.
- key_row is registered: key_row <= ~(1 << row_idx).
- At each edge, key_col is sampled for the row driven during the preceding cycle, which gives one full cycle of settling.
- Sample bits are inverted and stored into a 16-bit frame snapshot at bits [4r+3:4r].
- A frame completes on the edge that samples row 3. The frame result is then computed:
  - exactly one bit set: candidate = {pressed=1, code};
  - zero bits set, or two or more (ghosting): candidate = none.
- Stability counter (4 bits, saturating at DEBOUNCE_SCANS):
  - candidate equal to the previous frame's candidate: increment;
  - otherwise: load 1.
- Acceptance fires on the frame where the counter reaches exactly DEBOUNCE_SCANS:
  - pressed candidate: key_code <= code, key_held <= 1, key_valid <= 1 for one cycle;
  - none candidate: key_held <= 0; key_code retains its value; no strobe.
- Direct change from key A to key B without a release frame:
  - key_held stays 1 while B debounces;
  - B's acceptance strobes key_valid and updates key_code.
- Same key released and re-pressed: a new strobe requires a debounced release first.
- States: SCAN (row sweep, always running) plus the debounce status IDLE (key_held=0) / HELD (key_held=1). IDLE->HELD on pressed acceptance; HELD->IDLE on none acceptance; HELD->HELD on acceptance of a different key.

## Timing
- Reset values:
  - key_row = 4'b1111 (no row driven);
  - key_code = 0, key_valid = 0, key_held = 0;
  - row_idx = 0, snapshot = 0, stability counter = 0, previous candidate = none.
- Row 0 is first driven in the cycle after the first edge with reset low (edge 1).
- Edges 2..5 sample rows 0..3. Frame n completes at edge 1+4n.
- Press latency from a key stable before edge 1: key_valid is high in the cycle following edge 1+4*DEBOUNCE_SCANS.
- Worst-case press latency from an arbitrary press instant: 4*(DEBOUNCE_SCANS+1) cycles.
- key_valid is never high for two consecutive cycles.
- Reset asserted mid-frame: all state returns to reset values at that edge; the partial snapshot is discarded; scanning restarts at row 0.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - while key_held=1 and each frame's candidate equals key_code, a repeat counter counts frames after acceptance;
  - every REPEAT_FRAMES frames, key_valid pulses again with key_code unchanged;
  - the repeat counter clears on any non-matching frame or on reset.
- KEYPAD_REPEAT_EN undefined: no repeat logic; exactly one strobe per debounced press.

## Test plan
- Reset then idle (key_col = 4'b1111 constant) for 200 cycles -> key_row sweeps 1110,1101,1011,0111 from edge 1; key_valid never asserts; key_held = 0.
- Key 6 (row 1, col 2) held from reset release, DEBOUNCE_SCANS=4 -> single key_valid pulse in the cycle after edge 17; key_code = 6; key_held = 1 and remains 1.
- Key 6 held, then released -> key_held falls 4 frames after the first clean frame; key_code stays 6; no strobe.
- Key 6 chattering (toggling every 3 frames) -> no key_valid; key_held = 0.
- Keys 1 and 2 pressed together -> treated as none; no strobe; an already-held key is released after 4 frames.
- KEYPAD_REPEAT_EN defined, REPEAT_FRAMES=4, key 9 held for 40 frames -> initial strobe, then a strobe every 16 cycles, all with key_code = 9; undefined build -> exactly one strobe.
